// File: rtl/dist_frame_tx_if.sv
// Byte-level handshake between the distance frame builder and a UART transmitter.
// The master presents a byte with a one-cycle start strobe; the slave answers with a done pulse.
interface dist_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_done
  );
endinterface

// File: rtl/dist_frame_tx.sv
// Buffers per-channel distance samples and serialises them round-robin as UART byte frames:
// HEADER, channel, NB data bytes, XOR checksum.
module dist_frame_tx #(
  parameter int unsigned CH_NUM    = 2,
  parameter int unsigned DATA_W    = 16,
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM*DATA_W-1:0] dist_data,
  input  logic [CH_NUM-1:0]        dist_valid,
  input  logic                     ovr_clr,
  dist_frame_tx_if.master          tx,
  output logic                     frame_busy,
  output logic [CH_NUM-1:0]        overrun
);

  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned FrameLen = NB + 3;
  localparam int unsigned ChW      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned IdxW     = $clog2(FrameLen);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] hold_q [CH_NUM];
  logic [CH_NUM-1:0] pend_q, pend_d;
  logic [CH_NUM-1:0] ovr_q, ovr_d;
  logic [CH_NUM-1:0] sel_oh;
  logic [ChW-1:0]    rr_q, rr_d;
  logic [ChW-1:0]    sel_idx;
  logic              sel_found;
  logic [ChW-1:0]    chan_q, chan_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        next_byte;

  // Round-robin search starting at rr_q, wrapping modulo CH_NUM.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      cand = (32'(rr_q) + k) % CH_NUM;
      if (!sel_found && pend_q[ChW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = ChW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    chan_d    = chan_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    csum_d    = csum_q;
    sel_oh    = '0;
    next_byte = csum_q;
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          sel_oh[sel_idx] = 1'b1;
          rr_d      = (32'(sel_idx) == CH_NUM - 1) ? '0 : sel_idx + 1'b1;
          shift_d   = hold_q[sel_idx];
          chan_d    = sel_idx;
          idx_d     = '0;
          tx_data_d = HEADER;
          csum_d    = HEADER;
          state_d   = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (tx.tx_done) begin
          if (idx_q == IdxW'(FrameLen - 1)) begin
            state_d = StIdle;
          end else begin
            // idx_q is the byte just finished; pick the one after it.
            if (idx_q == '0) begin
              next_byte = 8'(chan_q);
            end else if (idx_q == IdxW'(NB + 1)) begin
              next_byte = csum_q;
            end else if (MSB_FIRST) begin
              next_byte = shift_q[DATA_W-1 -: 8];
              shift_d   = shift_q << 8;
            end else begin
              next_byte = shift_q[7:0];
              shift_d   = shift_q >> 8;
            end
            idx_d     = idx_q + 1'b1;
            tx_data_d = next_byte;
            csum_d    = csum_q ^ next_byte;
            state_d   = StStart;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A sample arriving on the channel being selected is kept pending without flagging overrun.
  always_comb begin
    pend_d = '0;
    ovr_d  = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      pend_d[i] = dist_valid[i] | (pend_q[i] & ~sel_oh[i]);
      ovr_d[i]  = (dist_valid[i] & pend_q[i] & ~sel_oh[i]) | (ovr_q[i] & ~ovr_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      ovr_q     <= '0;
      rr_q      <= '0;
      chan_q    <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      tx_data_q <= 8'h00;
      csum_q    <= 8'h00;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      rr_q      <= rr_d;
      chan_q    <= chan_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      csum_q    <= csum_d;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (dist_valid[i]) begin
          hold_q[i] <= dist_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign tx.tx_start = (state_q == StStart);
  assign tx.tx_data  = tx_data_q;
  assign frame_busy  = (state_q != StIdle);
  assign overrun     = ovr_q;

endmodule
